// File: rtl/arbiter_types.sv
// Shared types for the pmem arbiter: FSM state encoding and requester identity.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_t;

endpackage : arbiter_types

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter that serialises I-cache line reads and D-cache line
// reads/write-backs onto the single physical-memory port. Every output is a
// register; requester inputs are sampled only at grant time in IDLE.
module pmem_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,

  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  // Byte offset within a line; these address bits are forced to zero.
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_W / 8 - 1);

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

  arb_state_t state;
  requester_t last_grant;

  logic i_pending;
  logic d_pending;
  logic grant_i;
  logic grant_d;

  // Grant decision: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing
    // default here would infer a latch.
    i_pending = icache_read;
    d_pending = dcache_read | dcache_write;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    if (d_pending && (!i_pending || last_grant == ICACHE)) begin
      grant_d = 1'b1;
    end else if (i_pending) begin
      grant_i = 1'b1;
    end
  end

  // Transaction FSM: grant and latch in IDLE, hold pmem strobes until
  // pmem_resp, pulse the winner's resp for one cycle in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      // NOTE: the line-wide data registers are plain flops (not a memory
      // array), so they are reset along with the control state.
      state        <= IDLE;
      last_grant   <= DCACHE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      icache_rdata <= '0;
      icache_resp  <= 1'b0;
      dcache_rdata <= '0;
      dcache_resp  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_i) begin
            state        <= I_BUSY;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= line_align(icache_address);
            pmem_wdata   <= dcache_wdata;
          end else if (grant_d) begin
            // A simultaneous read and write from the D-cache is illegal;
            // the write-back is the one performed.
            state        <= D_BUSY;
            pmem_read    <= ~dcache_write;
            pmem_write   <= dcache_write;
            pmem_address <= line_align(dcache_address);
            pmem_wdata   <= dcache_wdata;
          end
        end

        I_BUSY: begin
          if (pmem_resp) begin
            state        <= RESP;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            icache_rdata <= pmem_rdata;
            icache_resp  <= 1'b1;
            last_grant   <= ICACHE;
          end
        end

        D_BUSY: begin
          if (pmem_resp) begin
            state        <= RESP;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            dcache_rdata <= pmem_rdata;
            dcache_resp  <= 1'b1;
            last_grant   <= DCACHE;
          end
        end

        RESP: begin
          state       <= IDLE;
          icache_resp <= 1'b0;
          dcache_resp <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : pmem_arbiter

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_pmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk;
  logic              reset_n;
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int total = 0;
  int bad   = 0;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  logic [127:0] line_a5;
  logic [127:0] line_dead;
  logic [127:0] line_other;
  logic [127:0] line_r0;
  logic [127:0] line_r1;
  logic [127:0] line_r2;
  logic [127:0] line_r3;

  initial begin
    line_a5    = {16{8'hA5}};
    line_dead  = {4{32'hDEADBEEF}};
    line_other = {4{32'h01234567}};
    line_r0    = {4{32'h0BAD_F00D}};
    line_r1    = {4{32'h1111_2222}};
    line_r2    = {4{32'h3333_4444}};
    line_r3    = {4{32'h5555_6666}};

    reset_n        = 1'b0;
    icache_read    = 1'b0;
    icache_address = '0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = '0;
    dcache_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    // ---- Reset state ----
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_pmem_read",    128'(pmem_read),    128'd0);
    check("rst_pmem_write",   128'(pmem_write),   128'd0);
    check("rst_pmem_address", 128'(pmem_address), 128'd0);
    check("rst_pmem_wdata",   pmem_wdata,         128'd0);
    check("rst_icache_resp",  128'(icache_resp),  128'd0);
    check("rst_dcache_resp",  128'(dcache_resp),  128'd0);
    check("rst_icache_rdata", icache_rdata,       128'd0);
    check("rst_dcache_rdata", dcache_rdata,       128'd0);

    // ---- I-read 0x1234, pmem answers in the third strobe cycle ----
    icache_read    = 1'b1;
    icache_address = 16'h1234;
    tick();
    check("ird_strobe_c1",  128'(pmem_read),    128'd1);
    check("ird_addr_c1",    128'(pmem_address), 128'h1230);
    check("ird_nowrite_c1", 128'(pmem_write),   128'd0);
    tick();
    check("ird_strobe_c2",  128'(pmem_read),    128'd1);
    check("ird_addr_c2",    128'(pmem_address), 128'h1230);
    tick();
    check("ird_strobe_c3",  128'(pmem_read),    128'd1);
    check("ird_addr_c3",    128'(pmem_address), 128'h1230);
    check("ird_noresp_c3",  128'(icache_resp),  128'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = line_a5;
    tick();
    check("ird_resp",       128'(icache_resp),  128'd1);
    check("ird_rdata",      icache_rdata,       line_a5);
    check("ird_dresp_0",    128'(dcache_resp),  128'd0);
    check("ird_strobe_off", 128'(pmem_read),    128'd0);
    icache_read = 1'b0;
    pmem_resp   = 1'b0;
    pmem_rdata  = '0;
    tick();
    check("ird_resp_1cyc",  128'(icache_resp),  128'd0);
    check("ird_rdata_hold", icache_rdata,       line_a5);

    // ---- D-write 0x0040; requester inputs change mid-transaction ----
    dcache_write   = 1'b1;
    dcache_address = 16'h0040;
    dcache_wdata   = line_dead;
    tick();
    check("dwr_strobe",  128'(pmem_write),   128'd1);
    check("dwr_noread",  128'(pmem_read),    128'd0);
    check("dwr_addr",    128'(pmem_address), 128'h0040);
    check("dwr_wdata",   pmem_wdata,         line_dead);
    dcache_wdata   = line_other;
    dcache_address = 16'h7770;
    tick();
    check("dwr_wdata_latched", pmem_wdata,         line_dead);
    check("dwr_addr_latched",  128'(pmem_address), 128'h0040);
    check("dwr_noread_2",      128'(pmem_read),    128'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = line_r0;
    tick();
    check("dwr_resp",       128'(dcache_resp), 128'd1);
    check("dwr_iresp_0",    128'(icache_resp), 128'd0);
    check("dwr_strobe_off", 128'(pmem_write),  128'd0);
    dcache_write = 1'b0;
    pmem_resp    = 1'b0;
    tick();
    check("dwr_resp_1cyc",  128'(dcache_resp), 128'd0);

    // ---- Spurious pmem_resp while IDLE ----
    pmem_resp = 1'b1;
    tick();
    tick();
    check("spur_iresp",  128'(icache_resp), 128'd0);
    check("spur_dresp",  128'(dcache_resp), 128'd0);
    check("spur_read",   128'(pmem_read),   128'd0);
    check("spur_write",  128'(pmem_write),  128'd0);
    pmem_resp = 1'b0;
    // A real request afterwards still gets a full BUSY phase (state stayed IDLE).
    icache_read    = 1'b1;
    icache_address = 16'h0ABF;
    tick();
    check("spur_then_read", 128'(pmem_read),    128'd1);
    check("spur_then_addr", 128'(pmem_address), 128'h0AB0);
    tick();
    check("spur_no_early_resp", 128'(icache_resp), 128'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = line_r3;
    tick();
    check("spur_then_resp", 128'(icache_resp), 128'd1);
    icache_read = 1'b0;
    pmem_resp   = 1'b0;
    tick();

    // ---- D read and write together: write wins ----
    dcache_read    = 1'b1;
    dcache_write   = 1'b1;
    dcache_address = 16'h0105;
    dcache_wdata   = line_other;
    tick();
    check("both_write", 128'(pmem_write),   128'd1);
    check("both_read",  128'(pmem_read),    128'd0);
    check("both_addr",  128'(pmem_address), 128'h0100);
    check("both_wdata", pmem_wdata,         line_other);
    pmem_resp  = 1'b1;
    pmem_rdata = line_r0;
    tick();
    check("both_resp",  128'(dcache_resp), 128'd1);
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    pmem_resp    = 1'b0;
    tick();

    // ---- Reset pulsed while in D_BUSY ----
    dcache_read    = 1'b1;
    dcache_address = 16'h4000;
    tick();
    check("rmid_busy", 128'(pmem_read), 128'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rmid_read",   128'(pmem_read),    128'd0);
    check("rmid_addr",   128'(pmem_address), 128'd0);
    check("rmid_wdata",  pmem_wdata,         128'd0);
    check("rmid_drdata", dcache_rdata,       128'd0);
    check("rmid_irdata", icache_rdata,       128'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = line_r3;
    tick();
    tick();
    check("rmid_no_dresp", 128'(dcache_resp), 128'd0);
    dcache_read = 1'b0;
    pmem_resp   = 1'b0;
    pmem_rdata  = '0;
    reset_n     = 1'b1;
    tick();
    check("rmid_idle_resp", 128'(dcache_resp), 128'd0);
    check("rmid_idle_read", 128'(pmem_read),   128'd0);

    // ---- Tie right after reset: I first; then tie again, D first; then I ----
    icache_read    = 1'b1;
    icache_address = 16'h2000;
    dcache_read    = 1'b1;
    dcache_address = 16'h3008;
    tick();
    check("tie1_addr_i", 128'(pmem_address), 128'h2000);
    check("tie1_read",   128'(pmem_read),    128'd1);
    pmem_resp  = 1'b1;
    pmem_rdata = line_r1;
    tick();
    check("tie1_iresp",  128'(icache_resp), 128'd1);
    check("tie1_irdata", icache_rdata,      line_r1);
    check("tie1_dresp",  128'(dcache_resp), 128'd0);
    icache_read = 1'b0;
    pmem_resp   = 1'b0;
    tick();
    check("tie1_gap_read", 128'(pmem_read),   128'd0);
    check("tie1_gap_resp", 128'(icache_resp), 128'd0);
    // IDLE cycle: I re-raises, D still waiting, last grant was I -> D wins.
    icache_read    = 1'b1;
    icache_address = 16'h2010;
    tick();
    check("tie2_addr_d", 128'(pmem_address), 128'h3000);
    check("tie2_read",   128'(pmem_read),    128'd1);
    pmem_resp  = 1'b1;
    pmem_rdata = line_r2;
    tick();
    check("tie2_dresp",     128'(dcache_resp), 128'd1);
    check("tie2_drdata",    dcache_rdata,      line_r2);
    check("tie2_iresp",     128'(icache_resp), 128'd0);
    check("tie2_irdata_hold", icache_rdata,    line_r1);
    dcache_read = 1'b0;
    pmem_resp   = 1'b0;
    tick();
    check("tie2_dresp_off", 128'(dcache_resp), 128'd0);
    tick();
    check("tie3_addr_i", 128'(pmem_address), 128'h2010);
    check("tie3_read",   128'(pmem_read),    128'd1);
    pmem_resp  = 1'b1;
    pmem_rdata = line_r3;
    tick();
    check("tie3_iresp",  128'(icache_resp), 128'd1);
    check("tie3_irdata", icache_rdata,      line_r3);
    check("tie3_drdata_hold", dcache_rdata, line_r2);
    icache_read = 1'b0;
    pmem_resp   = 1'b0;
    tick();
    check("tie3_iresp_off", 128'(icache_resp), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pmem_arbiter
